dm_responder: RTL

- Data-memory responder for the pipelined CPU's data-memory port. Serves load/store requests carrying address, store data, write strobe and dm_ctrl width code.
- Implements byte, halfword and word stores with byte-lane merging, and signed/unsigned load extension.
- Has a configurable access latency and signals completion on MIO_ready.
- Sits between the CPU's MEM-stage bus outputs and a word-organised RAM array held internally.

---
 rtl/dm_responder_if.sv | 22 ++
 rtl/dm_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dm_responder_if.sv
// Data-memory request/response bundle between the MEM stage and dm_responder.
interface dm_responder_if;
  logic        mem_req;
  logic        mem_w;
  logic [2:0]  dm_ctrl;
  logic [31:0] Addr_in;
  logic [31:0] Data_in;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic        busy;
  logic        mis_err;

  modport master (
    output mem_req, mem_w, dm_ctrl, Addr_in, Data_in,
    input  Data_out, MIO_ready, busy, mis_err
  );

  modport slave (
    input  mem_req, mem_w, dm_ctrl, Addr_in, Data_in,
    output Data_out, MIO_ready, busy, mis_err
  );
endinterface

// File: rtl/dm_responder.sv
// Word-organised data memory with lane-merged stores, extended loads
// and a fixed access latency signalled by a one-cycle MIO_ready pulse.
module dm_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [31:0] mem [2**ADDR_W];

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic              wr_q, wr_d;
  logic [31:0]       dout_q, dout_d;
  logic              err_q, err_d;

  logic              commit;
  logic              bad;
  logic              mem_we;
  logic [ADDR_W-1:0] idx;
  logic [1:0]        off;
  logic [31:0]       rword;
  logic [31:0]       rsh;
  logic [15:0]       rhalf;
  logic [31:0]       rdata;
  logic [31:0]       wrep;
  logic [3:0]        be;

  assign idx   = addr_q[ADDR_W+1:2];
  assign off   = addr_q[1:0];
  assign rword = mem[idx];
  assign rsh   = rword >> {off, 3'b000};
  assign rhalf = off[1] ? rword[31:16] : rword[15:0];

  // Lane enables, replicated store data, extended load data and
  // the error decision all come from the latched width code.
  always_comb begin
    be    = 4'h0;
    wrep  = wdata_q;
    rdata = 32'h0;
    bad   = 1'b1;
    unique case (ctrl_q)
      3'b000: begin
        be    = 4'hF;
        rdata = rword;
        bad   = (off != 2'b00);
      end
      3'b001, 3'b010: begin
        be    = off[1] ? 4'hC : 4'h3;
        wrep  = {2{wdata_q[15:0]}};
        rdata = ctrl_q[0] ? {{16{rhalf[15]}}, rhalf}
                          : {16'h0, rhalf};
        bad   = off[0];
      end
      3'b011, 3'b100: begin
        be    = 4'b0001 << off;
        wrep  = {4{wdata_q[7:0]}};
        rdata = ctrl_q[0] ? {{24{rsh[7]}}, rsh[7:0]}
                          : {24'h0, rsh[7:0]};
        bad   = 1'b0;
      end
      default: begin
        be    = 4'h0;
        wrep  = wdata_q;
        rdata = 32'h0;
        bad   = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctrl_d  = ctrl_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_req) begin
          addr_d  = bus.Addr_in[ADDR_W+1:0];
          wdata_d = bus.Data_in;
          ctrl_d  = bus.dm_ctrl;
          wr_d    = bus.mem_w;
          cnt_d   = WAIT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          err_d   = bad;
          dout_d  = (bad || wr_q) ? 32'h0 : rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      ctrl_q  <= 3'b000;
      wr_q    <= 1'b0;
      dout_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctrl_q  <= ctrl_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
    end
  end

  // Array has no reset; an aborted access never reaches commit.
  assign mem_we = commit && wr_q && !bad;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
      end
    end
  end

  assign bus.Data_out  = dout_q;
  assign bus.MIO_ready = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.mis_err   = err_q;

endmodule
